// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the serial BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_SIX  = 4'd6;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input logic [3:0] nibble);
    return nibble <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with optional nines' complement of b_d.
// Binary ripple sum first, then +6 correction whenever the raw sum exceeds 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c,
  input  logic       sub,
  output logic [3:0] s_d,
  output logic       c_out,
  output logic       invalid
);

  logic [3:0] b_x;
  logic [3:0] t_lo;
  logic [4:0] cy;
  logic       t_gt9;

  // Nines' complement wraps mod 16 for illegal digits; the result is then
  // meaningless but still well defined.
  assign b_x   = sub ? (BCD_NINE - b_d) : b_d;
  assign cy[0] = c;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    bcd_fa u_fa (
      .a_i(a_d[i]),
      .b_i(b_x[i]),
      .c_i(cy[i]),
      .s_o(t_lo[i]),
      .c_o(cy[i+1])
    );
  end

  // Five-bit raw sum {cy[4], t_lo} is greater than 9.
  assign t_gt9   = cy[4] | (t_lo[3] & (t_lo[2] | t_lo[1]));
  assign s_d     = t_gt9 ? (t_lo + BCD_SIX) : t_lo;
  assign c_out   = t_gt9;
  assign invalid = !is_bcd(a_d) || !is_bcd(b_d);

endmodule

// File: rtl/bcd_fa.sv
// One-bit full-adder cell used to build the digit adder ripple chain.
module bcd_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LS digit first,
// through a single shared bcd_digit_add slice, with start/done handshake.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit SUB_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic [W-1:0]   res_d;
  logic [CW-1:0]  cnt_q;
  logic           c_q;
  logic           sub_q;
  logic           err_acc_q;
  logic           last_digit;

  logic [3:0]     s_d;
  logic           c_out;
  logic           invalid;

  bcd_digit_add u_digit (
    .a_d    (a_q[3:0]),
    .b_d    (b_q[3:0]),
    .c      (c_q),
    .sub    (sub_q),
    .s_d    (s_d),
    .c_out  (c_out),
    .invalid(invalid)
  );

  // New digit enters at the top; after DIGITS shifts digit 0 sits in [3:0].
  if (DIGITS == 1) begin : g_res_one
    assign res_d = s_d;
  end else begin : g_res_many
    assign res_d = {s_d, res_q[W-1:4]};
  end

  assign last_digit = (cnt_q == CW'(DIGITS - 1));
  assign in_ready   = ~busy;

  // Control FSM, operand/result shift registers and registered outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would let later lines read already-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      sub_q     <= 1'b0;
      err_acc_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            c_q       <= cin;
            sub_q     <= SUB_EN ? sub : 1'b0;
            err_acc_q <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          a_q       <= a_q >> 4;
          b_q       <= b_q >> 4;
          c_q       <= c_out;
          res_q     <= res_d;
          err_acc_q <= err_acc_q | invalid;
          cnt_q     <= cnt_q + 1'b1;
          if (last_digit) begin
            sum     <= res_d;
            cout    <= c_out;
            err     <= err_acc_q | invalid;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub (DIGITS=4), plus DIGITS=1/8 smoke checks.
module tb_bcd_serial_addsub;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        err;
    bit          chk_sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, busy, done, cout, err;
  logic [15:0] sum;

  logic        start1 = 1'b0, in_ready1, busy1, done1, cout1, err1;
  logic [3:0]  a1 = '0, b1 = '0, sum1;
  logic        start8 = 1'b0, in_ready8, busy8, done8, cout8, err8;
  logic [31:0] a8 = '0, b8 = '0, sum8;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(4), .SUB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_addsub #(.DIGITS(1), .SUB_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_ready(in_ready1), .a(a1), .b(b1),
    .cin(1'b0), .sub(1'b0), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  bcd_serial_addsub #(.DIGITS(8), .SUB_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(1'b0), .sub(1'b0), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .err(err8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Decimal reference: result = A + (B or 9999-B) + cin, taken mod 10^4.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_v,
                                 input logic tc, input logic ts);
    exp_t   m;
    longint av = 0, bv = 0, r;
    bit     bad_dig = 0;
    logic [3:0] d;
    for (int i = 3; i >= 0; i--) begin
      d = ta[4*i +: 4];
      if (d > 4'd9) bad_dig = 1;
      av = av * 10 + longint'(d);
      d = tb_v[4*i +: 4];
      if (d > 4'd9) bad_dig = 1;
      bv = bv * 10 + longint'(d);
    end
    r = av + (ts ? (9999 - bv) : bv) + longint'(tc);
    m.cout = (r >= 10000);
    r = r % 10000;
    m.sum = '0;
    for (int i = 0; i < 4; i++) begin
      m.sum[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    m.err     = bad_dig;
    m.chk_sum = !bad_dig;
    return m;
  endfunction

  // Scoreboard consumer: every done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done && prev_done) check("done_width", 1, 0);
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.chk_sum) check("sum", sum, e.sum);
        if (e.chk_sum) check("cout", cout, e.cout);
        check("err", err, e.err);
      end
    end
    prev_done = done;
  end

  // Issue one operation from a negedge; returns at the negedge where done=1.
  // With inject set, a second start with other operands is raised mid-run.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic ts, input bit inject);
    int n;
    bit rdy_ok;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    sb.push_back(model(ta, tb_v, tc, ts));
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    rdy_ok = 1;
    while (n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
      if (in_ready) rdy_ok = 0;
      start = (inject && n == 2);
      if (start) begin
        a = 16'h7777; b = 16'h2222; cin = 1'b1; sub = ~ts;
      end
    end
    start = 1'b0;
    check("latency", n, 4);
    check("in_ready_run", rdy_ok, 1);
    check("in_ready_at_done", in_ready, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);

    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h9999, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h5000, 16'h1234, 1'b1, 1'b1, 0);
    run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 0);
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'h0042, 16'h0057, 1'b0, 1'b0, 0);
    // Ignored mid-run start, then back-to-back operations.
    run_op(16'h4321, 16'h1111, 1'b1, 1'b1, 1);
    run_op(16'h0808, 16'h0909, 1'b1, 1'b0, 0);
    run_op(16'h2468, 16'h1357, 1'b0, 1'b1, 0);

    // Asynchronous reset two cycles into a run: outputs clear at once, no done.
    a = 16'h3333; b = 16'h4444; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready", in_ready, 1);
    repeat (6) @(negedge clk);
    run_op(16'h0517, 16'h0283, 1'b0, 1'b0, 0);

    // DIGITS=1: 9+9 completes after a single RUN cycle.
    a1 = 4'h9; b1 = 4'h9; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done1) break;
    end
    check("d1_latency", n, 1);
    check("d1_sum", sum1, 4'h8);
    check("d1_cout", cout1, 1);
    check("d1_err", err1, 0);

    // DIGITS=8: 99999999+9 wraps to 8 with carry out.
    a8 = 32'h9999_9999; b8 = 32'h0000_0009; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done8) break;
    end
    check("d8_latency", n, 8);
    check("d8_sum", sum8, 32'h0000_0008);
    check("d8_cout", cout8, 1);

    repeat (6) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
